// File: rtl/blockram_access_scheduler_pkg.sv
// Shared types and constants for the block-RAM access scheduler and its arbiter.
package blockram_access_scheduler_pkg;

  localparam int DEFAULT_ENTRY_W     = 64;
  localparam int DEFAULT_NUMBER_SET  = 64;
  localparam int DEFAULT_SET_PTR_W   = $clog2(DEFAULT_NUMBER_SET);
  localparam int DEFAULT_NUM_REQ     = 2;
  localparam int DEFAULT_REQ_PTR_W   = $clog2(DEFAULT_NUM_REQ);

  typedef enum logic {
    STATE_INIT = 1'b0,
    STATE_RUN  = 1'b1
  } sched_state_e;

  // Low bit of client idx's field inside a packed per-client bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/blockram_access_scheduler_round_robin_arbiter.sv
// Round-robin arbiter: grants the first requester after the pointer, wrapping around.
module blockram_access_scheduler_round_robin_arbiter #(
  parameter int NUM_REQUESTER = 2,
  parameter int PTR_W         = (NUM_REQUESTER > 1) ? $clog2(NUM_REQUESTER) : 1
) (
  input  logic [NUM_REQUESTER-1:0] req_in,
  input  logic [PTR_W-1:0]         ptr_in,
  input  logic                     en_in,
  output logic [NUM_REQUESTER-1:0] grant_out,
  output logic [PTR_W-1:0]         idx_out,
  output logic                     valid_out
);

  always_comb begin
    int cand;
    grant_out = '0;
    idx_out   = '0;
    valid_out = 1'b0;
    cand      = 0;
    if (en_in) begin
      for (int k = 1; k <= NUM_REQUESTER; k++) begin
        cand = (int'(ptr_in) + k) % NUM_REQUESTER;
        if (!valid_out && req_in[cand]) begin
          valid_out       = 1'b1;
          grant_out[cand] = 1'b1;
          idx_out         = PTR_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/blockram_access_scheduler.sv
// Shares one read-first block RAM among several clients: init sweep after reset,
// then one round-robin access per cycle with a response one cycle later.
module blockram_access_scheduler
  import blockram_access_scheduler_pkg::*;
#(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS   = DEFAULT_ENTRY_W,
  parameter int NUMBER_SET                  = DEFAULT_NUMBER_SET,
  parameter int SET_PTR_WIDTH_IN_BITS       = DEFAULT_SET_PTR_W,
  parameter int NUM_REQUESTER               = DEFAULT_NUM_REQ,
  parameter int REQUESTER_PTR_WIDTH_IN_BITS = DEFAULT_REQ_PTR_W,
  parameter logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] INIT_ENTRY = '0
) (
  input  logic                                               clk_in,
  input  logic                                               reset_n_in,
  input  logic [NUM_REQUESTER-1:0]                           req_valid_in,
  input  logic [NUM_REQUESTER-1:0]                           req_write_in,
  input  logic [NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]     req_set_addr_in,
  input  logic [NUM_REQUESTER*SINGLE_ENTRY_SIZE_IN_BITS-1:0] req_entry_in,
  output logic [NUM_REQUESTER-1:0]                           req_ack_out,
  output logic                                               resp_valid_out,
  output logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0]             resp_requester_out,
  output logic                                               resp_is_write_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]               resp_entry_out,
  output logic                                               init_done_out,
  output logic                                               ram_read_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                   ram_read_set_addr_out,
  output logic                                               ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                   ram_write_set_addr_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]               ram_write_entry_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]               ram_read_entry_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]               ram_evict_entry_in
);

  localparam logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0] RR_RESET =
    REQUESTER_PTR_WIDTH_IN_BITS'(NUM_REQUESTER - 1);
  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET =
    SET_PTR_WIDTH_IN_BITS'(NUMBER_SET - 1);

  sched_state_e                             state_q, state_d;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]         cnt_q, cnt_d;
  logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic                                     init_done_q, init_done_d;
  logic                                     resp_valid_q, resp_valid_d;
  logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0]   resp_req_q, resp_req_d;
  logic                                     resp_is_write_q, resp_is_write_d;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]     resp_hold_q, resp_hold_d;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]         rd_addr_q, rd_addr_d;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]         wr_addr_q, wr_addr_d;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]     wr_entry_q, wr_entry_d;
  logic                                     rd_en, wr_en;

  logic [NUM_REQUESTER-1:0]                 grant;
  logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0]   gidx;
  logic                                     gvalid;
  logic                                     arb_en;

  // The evict port duplicates the read data for writes; only the read port is consumed.
  logic unused_evict;
  assign unused_evict = ^ram_evict_entry_in;

  assign arb_en = reset_n_in && (state_q == STATE_RUN);

  blockram_access_scheduler_round_robin_arbiter #(
    .NUM_REQUESTER (NUM_REQUESTER),
    .PTR_W         (REQUESTER_PTR_WIDTH_IN_BITS)
  ) u_arb (
    .req_in    (req_valid_in),
    .ptr_in    (rr_ptr_q),
    .en_in     (arb_en),
    .grant_out (grant),
    .idx_out   (gidx),
    .valid_out (gvalid)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rr_ptr_d        = rr_ptr_q;
    init_done_d     = init_done_q;
    resp_valid_d    = 1'b0;
    resp_req_d      = resp_req_q;
    resp_is_write_d = resp_is_write_q;
    resp_hold_d     = resp_valid_q ? ram_read_entry_in : resp_hold_q;
    rd_addr_d       = rd_addr_q;
    wr_addr_d       = wr_addr_q;
    wr_entry_d      = wr_entry_q;
    rd_en           = 1'b0;
    wr_en           = 1'b0;
    unique case (state_q)
      STATE_INIT: begin
        // The RAM drops writes without a read enable, so the sweep asserts both.
        rd_en      = 1'b1;
        wr_en      = 1'b1;
        rd_addr_d  = cnt_q;
        wr_addr_d  = cnt_q;
        wr_entry_d = INIT_ENTRY;
        cnt_d      = cnt_q + SET_PTR_WIDTH_IN_BITS'(1);
        if (cnt_q == LAST_SET) begin
          state_d     = STATE_RUN;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      STATE_RUN: begin
        if (gvalid) begin
          rd_en           = 1'b1;
          rd_addr_d       = req_set_addr_in[slice_lo(int'(gidx), SET_PTR_WIDTH_IN_BITS) +:
                                            SET_PTR_WIDTH_IN_BITS];
          rr_ptr_d        = gidx;
          resp_valid_d    = 1'b1;
          resp_req_d      = gidx;
          resp_is_write_d = req_write_in[gidx];
          if (req_write_in[gidx]) begin
            wr_en      = 1'b1;
            wr_addr_d  = rd_addr_d;
            wr_entry_d = req_entry_in[slice_lo(int'(gidx), SINGLE_ENTRY_SIZE_IN_BITS) +:
                                      SINGLE_ENTRY_SIZE_IN_BITS];
          end
        end
      end
      default: state_d = STATE_INIT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q         <= STATE_INIT;
      cnt_q           <= '0;
      rr_ptr_q        <= RR_RESET;
      init_done_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_req_q      <= '0;
      resp_is_write_q <= 1'b0;
      resp_hold_q     <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rr_ptr_q        <= rr_ptr_d;
      init_done_q     <= init_done_d;
      resp_valid_q    <= resp_valid_d;
      resp_req_q      <= resp_req_d;
      resp_is_write_q <= resp_is_write_d;
      resp_hold_q     <= resp_hold_d;
    end
  end

  always_ff @(posedge clk_in) begin
    rd_addr_q  <= rd_addr_d;
    wr_addr_q  <= wr_addr_d;
    wr_entry_q <= wr_entry_d;
  end

  assign req_ack_out            = grant;
  assign ram_read_en_out        = rd_en & reset_n_in;
  assign ram_write_en_out       = wr_en & reset_n_in;
  assign ram_read_set_addr_out  = rd_addr_d;
  assign ram_write_set_addr_out = wr_addr_d;
  assign ram_write_entry_out    = wr_entry_d;

  // Read data arrives from the RAM's output register in the cycle after issue.
  assign resp_valid_out     = resp_valid_q;
  assign resp_requester_out = resp_req_q;
  assign resp_is_write_out  = resp_is_write_q;
  assign resp_entry_out     = resp_valid_q ? ram_read_entry_in : resp_hold_q;
  assign init_done_out      = init_done_q;

endmodule

// File: tb/tb_blockram_access_scheduler.sv
// Bench for blockram_access_scheduler: behavioural RAM plus a reference model of the scheduler.
module tb_blockram_access_scheduler;

  localparam int E  = 64;
  localparam int NS = 64;
  localparam int AW = 6;
  localparam int NR = 2;
  localparam int RW = 1;
  localparam logic [E-1:0] INIT_V = 64'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*E-1:0]  req_entry = '0;
  logic [NR-1:0]    req_ack_out;
  logic             resp_valid_out;
  logic [RW-1:0]    resp_requester_out;
  logic             resp_is_write_out;
  logic [E-1:0]     resp_entry_out;
  logic             init_done_out;
  logic             ram_re, ram_we;
  logic [AW-1:0]    ram_raddr, ram_waddr;
  logic [E-1:0]     ram_wdata;
  logic [E-1:0]     ram_rd_q = '0;
  logic [E-1:0]     ram_ev_q = '0;
  logic [E-1:0]     ram_mem [NS];

  blockram_access_scheduler #(
    .SINGLE_ENTRY_SIZE_IN_BITS   (E),
    .NUMBER_SET                  (NS),
    .SET_PTR_WIDTH_IN_BITS       (AW),
    .NUM_REQUESTER               (NR),
    .REQUESTER_PTR_WIDTH_IN_BITS (RW),
    .INIT_ENTRY                  (INIT_V)
  ) dut (
    .clk_in                 (clk),
    .reset_n_in             (reset_n),
    .req_valid_in           (req_valid),
    .req_write_in           (req_write),
    .req_set_addr_in        (req_addr),
    .req_entry_in           (req_entry),
    .req_ack_out            (req_ack_out),
    .resp_valid_out         (resp_valid_out),
    .resp_requester_out     (resp_requester_out),
    .resp_is_write_out      (resp_is_write_out),
    .resp_entry_out         (resp_entry_out),
    .init_done_out          (init_done_out),
    .ram_read_en_out        (ram_re),
    .ram_read_set_addr_out  (ram_raddr),
    .ram_write_en_out       (ram_we),
    .ram_write_set_addr_out (ram_waddr),
    .ram_write_entry_out    (ram_wdata),
    .ram_read_entry_in      (ram_rd_q),
    .ram_evict_entry_in     (ram_ev_q)
  );

  // Read-first RAM with registered outputs; writes need the read enable.
  always @(posedge clk) begin
    if (ram_re) begin
      ram_rd_q <= ram_mem[ram_raddr];
      ram_ev_q <= ram_mem[ram_waddr];
      if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the outputs must be after the most recent posedge.
  logic [E-1:0]  m_mem [NS];
  bit            m_run = 1'b0;
  bit            m_done = 1'b0;
  int            m_sweep = 0;
  int            m_last = NR - 1;
  bit            m_rv = 1'b0;
  int            m_rreq = 0;
  bit            m_rwr = 1'b0;
  logic [E-1:0]  m_rdata = '0;
  logic [E-1:0]  m_hold = '0;
  logic [AW-1:0] m_raddr = '0;
  logic [AW-1:0] m_waddr = '0;
  logic [NR-1:0] ack_s = '0;

  always @(negedge clk) begin : model_cmp
    int            w;
    logic [AW-1:0] a;
    logic [E-1:0]  d;
    logic [NR-1:0] ea;
    ack_s = req_ack_out;
    chk("resp_valid", 64'(resp_valid_out), 64'(m_rv));
    if (m_rv) begin
      chk("resp_requester", 64'(resp_requester_out), 64'(m_rreq));
      chk("resp_is_write", 64'(resp_is_write_out), 64'(m_rwr));
      chk("resp_entry", resp_entry_out, m_rdata);
    end else begin
      chk("resp_entry_hold", resp_entry_out, m_hold);
    end
    chk("init_done", 64'(init_done_out), 64'(m_done));

    if (!reset_n) begin
      chk("rst_ack", 64'(req_ack_out), 64'd0);
      chk("rst_ren", 64'(ram_re), 64'd0);
      chk("rst_wen", 64'(ram_we), 64'd0);
      m_run = 1'b0; m_done = 1'b0; m_sweep = 0; m_last = NR - 1;
      m_rv = 1'b0; m_hold = '0;
    end else if (!m_run) begin
      chk("init_ack", 64'(req_ack_out), 64'd0);
      chk("init_ren", 64'(ram_re), 64'd1);
      chk("init_wen", 64'(ram_we), 64'd1);
      chk("init_raddr", 64'(ram_raddr), 64'(m_sweep));
      chk("init_waddr", 64'(ram_waddr), 64'(m_sweep));
      chk("init_wdata", ram_wdata, INIT_V);
      m_mem[m_sweep] = INIT_V;
      m_raddr = AW'(m_sweep);
      m_waddr = AW'(m_sweep);
      if (m_rv) m_hold = m_rdata;
      m_rv = 1'b0;
      m_sweep++;
      if (m_sweep == NS) begin m_run = 1'b1; m_done = 1'b1; end
    end else begin
      w = -1;
      for (int k = 1; k <= NR; k++)
        if (w < 0 && req_valid[(m_last + k) % NR]) w = (m_last + k) % NR;
      if (m_rv) m_hold = m_rdata;
      if (w < 0) begin
        chk("idle_ack", 64'(req_ack_out), 64'd0);
        chk("idle_ren", 64'(ram_re), 64'd0);
        chk("idle_wen", 64'(ram_we), 64'd0);
        chk("idle_raddr_hold", 64'(ram_raddr), 64'(m_raddr));
        chk("idle_waddr_hold", 64'(ram_waddr), 64'(m_waddr));
        m_rv = 1'b0;
      end else begin
        a = req_addr[w*AW +: AW];
        d = req_entry[w*E +: E];
        ea = '0;
        ea[w] = 1'b1;
        chk("run_ack", 64'(req_ack_out), 64'(ea));
        chk("run_ren", 64'(ram_re), 64'd1);
        chk("run_raddr", 64'(ram_raddr), 64'(a));
        chk("run_wen", 64'(ram_we), 64'(req_write[w]));
        if (req_write[w]) begin
          chk("run_waddr", 64'(ram_waddr), 64'(a));
          chk("run_wdata", ram_wdata, d);
        end
        m_rv = 1'b1; m_rreq = w; m_rwr = req_write[w];
        m_rdata = m_mem[a];
        if (req_write[w]) begin
          m_mem[a] = d;
          m_waddr = a;
        end
        m_raddr = a;
        m_last = w;
      end
    end
  end

  task automatic set_req(input int i, input bit v, input bit wr,
                         input logic [AW-1:0] a, input logic [E-1:0] d);
    req_valid[i] = v;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_entry[i*E +: E] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp_valid", 64'(resp_valid_out), 64'd0);
    chk("reset_resp_req", 64'(resp_requester_out), 64'd0);
    chk("reset_resp_wr", 64'(resp_is_write_out), 64'd0);
    chk("reset_resp_entry", resp_entry_out, 64'd0);
    chk("reset_init_done", 64'(init_done_out), 64'd0);
    chk("reset_ren", 64'(ram_re), 64'd0);
    reset_n = 1'b1;
    set_req(1, 1'b1, 1'b0, 6'd63, '0);

    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk("sweep_no_ack", 64'(req_ack_out), 64'd0);
      if (k == 1) begin
        chk("sweep_first_wen", 64'(ram_we), 64'd1);
        chk("sweep_first_addr", 64'(ram_waddr), 64'd0);
      end
      if (k == 64) begin
        chk("sweep_last_addr", 64'(ram_waddr), 64'd63);
        chk("sweep_last_done", 64'(init_done_out), 64'd0);
      end
    end
    @(negedge clk);
    chk("cycle65_init_done", 64'(init_done_out), 64'd1);
    chk("cycle65_ack_held_req", 64'(req_ack_out), 64'd2);

    next_cycle();
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_req(0, 1'b1, 1'b1, 6'd5, 64'h1234);
    @(negedge clk);
    chk("set63_resp_valid", 64'(resp_valid_out), 64'd1);
    chk("set63_resp_req", 64'(resp_requester_out), 64'd1);
    chk("set63_resp_entry", resp_entry_out, 64'hA5);
    chk("write_ack", 64'(req_ack_out), 64'd1);

    next_cycle();
    set_req(0, 1'b1, 1'b0, 6'd5, '0);
    @(negedge clk);
    chk("write_resp_is_write", 64'(resp_is_write_out), 64'd1);
    chk("write_resp_old", resp_entry_out, 64'hA5);
    chk("read_ack", 64'(req_ack_out), 64'd1);

    next_cycle();
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("read_resp_is_write", 64'(resp_is_write_out), 64'd0);
    chk("read_resp_new", resp_entry_out, 64'h1234);

    next_cycle();
    set_req(1, 1'b1, 1'b0, 6'd7, '0);
    @(negedge clk);
    chk("idle_prelude_ack", 64'(req_ack_out), 64'd2);
    next_cycle();
    set_req(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_no_ren", 64'(ram_re), 64'd0);
      chk("idle_no_wen", 64'(ram_we), 64'd0);
      next_cycle();
    end

    set_req(0, 1'b1, 1'b0, 6'd10, '0);
    set_req(1, 1'b1, 1'b0, 6'd11, '0);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j < 6) chk("contention_ack", 64'(req_ack_out), (j % 2 == 0) ? 64'd1 : 64'd2);
      if (j > 0) chk("contention_resp_req", 64'(resp_requester_out), 64'((j - 1) % 2));
      next_cycle();
      if (j == 5) begin
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
      end
    end

    set_req(0, 1'b1, 1'b0, 6'd5, '0);
    @(negedge clk);
    chk("pre_reset_ack", 64'(req_ack_out), 64'd1);
    next_cycle();
    set_req(0, 1'b0, 1'b0, '0, '0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_pending_visible", 64'(resp_valid_out), 64'd1);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_resp_dropped", 64'(resp_valid_out), 64'd0);
    chk("midrst_init_done", 64'(init_done_out), 64'd0);
    chk("midrst_sweep_wen", 64'(ram_we), 64'd1);
    chk("midrst_sweep_addr0", 64'(ram_waddr), 64'd0);
    repeat (70) next_cycle();

    for (int n = 0; n < 3000; n++) begin
      reset_n = (n != 1500);
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || ack_s[i]) begin
          set_req(i, ($urandom % 4) != 0, $urandom % 2 == 1,
                  ($urandom % 4 == 0) ? 6'd63 : AW'($urandom % 8),
                  {$urandom, $urandom});
        end
      end
      next_cycle();
    end

    req_valid = '0;
    repeat (3) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
